// File: rtl/cal_pkg.sv
// Calendar constants, FSM encoding and month-length/leap helpers shared by
// the day counter and the month/year counter.
package cal_pkg;

  localparam logic [3:0] JAN = 4'd1;
  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] MAR = 4'd3;
  localparam logic [3:0] APR = 4'd4;
  localparam logic [3:0] MAY = 4'd5;
  localparam logic [3:0] JUN = 4'd6;
  localparam logic [3:0] JUL = 4'd7;
  localparam logic [3:0] AUG = 4'd8;
  localparam logic [3:0] SEP = 4'd9;
  localparam logic [3:0] OCT = 4'd10;
  localparam logic [3:0] NOV = 4'd11;
  localparam logic [3:0] DEC = 4'd12;

  localparam logic [5:0] DIM_31 = 6'd31;
  localparam logic [5:0] DIM_30 = 6'd30;
  localparam logic [5:0] DIM_29 = 6'd29;
  localparam logic [5:0] DIM_28 = 6'd28;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FIX    = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  function automatic logic [5:0] days_in_month(input logic [3:0] mon, input logic lp);
    logic [5:0] d;
    case (mon)
      FEB:                d = lp ? DIM_29 : DIM_28;
      APR, JUN, SEP, NOV: d = DIM_30;
      default:            d = DIM_31;
    endcase
    return d;
  endfunction

  function automatic logic is_leap(input logic [1:0] r4, input logic [6:0] r100,
                                   input logic [8:0] r400);
    return (r4 == 2'd0) && ((r100 != 7'd0) || (r400 == 9'd0));
  endfunction

endpackage

// File: rtl/mod400_div.sv
// Restoring divider producing year % 400, one dividend bit per cycle (16 cycles).
// o_done is high during the final step; o_rem is valid from the following cycle.
module mod400_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_dividend,
  output logic        o_done,
  output logic [8:0]  o_rem
);

  localparam logic [9:0] DIVISOR = 10'd400;

  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [15:0] r_dvd;
  logic [8:0]  r_rem;
  logic [9:0]  w_trial;
  logic [8:0]  w_rem_next;

  // r_rem < 400, so the shifted trial value stays below 800 and fits 10 bits
  assign w_trial    = {r_rem, r_dvd[15]};
  assign w_rem_next = (w_trial >= DIVISOR) ? 9'(w_trial - DIVISOR) : w_trial[8:0];
  assign o_done     = r_busy && (r_cnt == 4'd15);
  assign o_rem      = r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= 4'd0;
      r_dvd  <= 16'd0;
      r_rem  <= 9'd0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= 4'd0;
      r_dvd  <= i_dividend;
      r_rem  <= 9'd0;
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_dvd <= {r_dvd[14:0], 1'b0};
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'd15) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/cnt_month_year.sv
// Month/year counter fed by the day counter's rollover strobe; also accepts a
// validated date set that recomputes the leap remainders over 18 cycles.
module cnt_month_year #(
  parameter int unsigned YEAR_MIN = 2000,
  parameter int unsigned YEAR_MAX = 2099
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_month,
  input  logic        set_valid,
  output logic        set_ready,
  input  logic [3:0]  set_month,
  input  logic [15:0] set_year,
  output logic        set_done,
  output logic        set_err,
  output logic [3:0]  month,
  output logic [15:0] year,
  output logic        leap,
  output logic [5:0]  days_in_month,
  output logic        year_wrap,
  output logic        inc_ovf
);
  import cal_pkg::*;

  localparam logic [15:0] C_YMIN = 16'(YEAR_MIN);
  localparam logic [15:0] C_YMAX = 16'(YEAR_MAX);
  localparam logic [1:0]  C_R4   = 2'(YEAR_MIN % 4);
  localparam logic [6:0]  C_R100 = 7'(YEAR_MIN % 100);
  localparam logic [8:0]  C_R400 = 9'(YEAR_MIN % 400);
  localparam logic        C_LEAP = is_leap(C_R4, C_R100, C_R400);

  state_t      r_state;
  logic [3:0]  r_month, r_set_month;
  logic [15:0] r_year, r_set_year;
  logic [1:0]  r_r4;
  logic [6:0]  r_r100, r_r100_fix;
  logic [8:0]  r_r400;
  logic        r_leap, r_pending, r_inc_ovf, r_set_ready;
  logic        r_set_done, r_set_err, r_year_wrap;
  logic [5:0]  r_dim;

  logic [3:0]  w_inc_month;
  logic [15:0] w_inc_year;
  logic [1:0]  w_inc_r4;
  logic [6:0]  w_inc_r100, w_fix_r100;
  logic [8:0]  w_inc_r400, w_div_rem;
  logic        w_inc_wrap, w_inc_leap, w_set_ok, w_div_start, w_div_done, w_commit_leap;

  always_comb begin
    w_inc_month = r_month + 4'd1;
    w_inc_year  = r_year;
    w_inc_r4    = r_r4;
    w_inc_r100  = r_r100;
    w_inc_r400  = r_r400;
    w_inc_wrap  = 1'b0;
    if (r_month == DEC) begin
      w_inc_month = JAN;
      if (r_year == C_YMAX) begin
        w_inc_year = C_YMIN;
        w_inc_r4   = C_R4;
        w_inc_r100 = C_R100;
        w_inc_r400 = C_R400;
        w_inc_wrap = 1'b1;
      end else begin
        w_inc_year = r_year + 16'd1;
        w_inc_r4   = r_r4 + 2'd1;
        w_inc_r100 = (r_r100 == 7'd99)  ? 7'd0 : r_r100 + 7'd1;
        w_inc_r400 = (r_r400 == 9'd399) ? 9'd0 : r_r400 + 9'd1;
      end
    end
  end

  assign w_inc_leap  = is_leap(w_inc_r4, w_inc_r100, w_inc_r400);
  assign w_set_ok    = (set_month >= JAN) && (set_month <= DEC) &&
                       (set_year >= C_YMIN) && (set_year <= C_YMAX);
  assign w_div_start = (r_state == ST_IDLE) && set_valid && w_set_ok;
  assign w_fix_r100  = (w_div_rem >= 9'd300) ? 7'(w_div_rem - 9'd300) :
                       (w_div_rem >= 9'd200) ? 7'(w_div_rem - 9'd200) :
                       (w_div_rem >= 9'd100) ? 7'(w_div_rem - 9'd100) : 7'(w_div_rem);
  assign w_commit_leap = is_leap(r_set_year[1:0], r_r100_fix, w_div_rem);

  mod400_div u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (set_year),
    .o_done     (w_div_done),
    .o_rem      (w_div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_month     <= JAN;
      r_year      <= C_YMIN;
      r_r4        <= C_R4;
      r_r100      <= C_R100;
      r_r400      <= C_R400;
      r_leap      <= C_LEAP;
      r_dim       <= DIM_31;
      r_set_month <= JAN;
      r_set_year  <= C_YMIN;
      r_r100_fix  <= 7'd0;
      r_pending   <= 1'b0;
      r_inc_ovf   <= 1'b0;
      r_set_ready <= 1'b1;
      r_set_done  <= 1'b0;
      r_set_err   <= 1'b0;
      r_year_wrap <= 1'b0;
    end else begin
      r_set_done  <= 1'b0;
      r_set_err   <= 1'b0;
      r_year_wrap <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // an increment is applied even when a set is accepted alongside it
          if (inc_month) begin
            r_month     <= w_inc_month;
            r_year      <= w_inc_year;
            r_r4        <= w_inc_r4;
            r_r100      <= w_inc_r100;
            r_r400      <= w_inc_r400;
            r_leap      <= w_inc_leap;
            r_dim       <= cal_pkg::days_in_month(w_inc_month, w_inc_leap);
            r_year_wrap <= w_inc_wrap;
          end
          if (set_valid) begin
            if (w_set_ok) begin
              r_set_month <= set_month;
              r_set_year  <= set_year;
              r_set_ready <= 1'b0;
              r_state     <= ST_CALC;
            end else begin
              r_set_err <= 1'b1;
            end
          end
        end
        ST_CALC: if (w_div_done) r_state <= ST_FIX;
        ST_FIX: begin
          r_r100_fix <= w_fix_r100;
          r_state    <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_month     <= r_set_month;
          r_year      <= r_set_year;
          r_r4        <= r_set_year[1:0];
          r_r100      <= r_r100_fix;
          r_r400      <= w_div_rem;
          r_leap      <= w_commit_leap;
          r_dim       <= cal_pkg::days_in_month(r_set_month, w_commit_leap);
          r_pending   <= 1'b0;
          r_set_done  <= 1'b1;
          r_set_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      // the committed date supersedes any held increment
      if (inc_month && (r_state != ST_IDLE)) begin
        if (r_pending) r_inc_ovf <= 1'b1;
        else if (r_state != ST_COMMIT) r_pending <= 1'b1;
      end
    end
  end

  assign set_ready     = r_set_ready;
  assign set_done      = r_set_done;
  assign set_err       = r_set_err;
  assign month         = r_month;
  assign year          = r_year;
  assign leap          = r_leap;
  assign days_in_month = r_dim;
  assign year_wrap     = r_year_wrap;
  assign inc_ovf       = r_inc_ovf;

endmodule
